blocking_caveat_core: RTL and testbench

BLOCKING_CAVEAT_CORE -- requirements
Module: blocking_caveat

---
 rtl/blocking_caveat_core.sv | 62 ++++++
 tb/tb_blocking_caveat_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/blocking_caveat_core.sv
// Registered (a|b)&c next to a copy whose OR term is taken one cycle late.
// The copy mimics a blocking-assignment ordering bug; a flag and a saturating counter report where the two disagree.
module blocking_caveat_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             cnt_clr,
  output logic             d,
  output logic             d_stale,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_x;
  logic             r_d;
  logic             r_d_stale;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_cnt;

  logic w_or;
  logic w_d_next;
  logic w_stale_next;
  logic w_mis_next;

  assign w_or         = a | b;
  assign w_d_next     = w_or & c;
  // The stale path reads the OR term held in r_x, which is the value from before this edge.
  assign w_stale_next = r_x & c;
  assign w_mis_next   = w_d_next ^ w_stale_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x        <= 1'b0;
      r_d        <= 1'b0;
      r_d_stale  <= 1'b0;
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_x        <= w_or;
      r_d        <= w_d_next;
      r_d_stale  <= w_stale_next;
      r_mismatch <= w_mis_next;
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_mis_next && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign d            = r_d;
  assign d_stale      = r_d_stale;
  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_cnt;

endmodule

// File: tb/tb_blocking_caveat_core.sv
// Directed bench for blocking_caveat_core: a default-width instance and a 2-bit-counter
// instance share the same stimulus, and each scenario task checks its own expected values.
module tb_blocking_caveat_core;

  logic        clk;
  logic        reset_n;
  logic        a;
  logic        b;
  logic        c;
  logic        cnt_clr;
  logic        d;
  logic        d_stale;
  logic        mismatch;
  logic [15:0] mismatch_cnt;
  logic        s_d;
  logic        s_d_stale;
  logic        s_mismatch;
  logic [1:0]  s_mismatch_cnt;

  int n_cmp;
  int n_fail;

  blocking_caveat_core #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
    .d(d), .d_stale(d_stale), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
  );

  blocking_caveat_core #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
    .d(s_d), .d_stale(s_d_stale), .mismatch(s_mismatch), .mismatch_cnt(s_mismatch_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge, then settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cnt_clr = 1'b0; a = 1'b1; b = 1'b1; c = 1'b1;
    tick;
    tick;
    n_cmp++; if (d !== 1'b0) begin n_fail++; $display("FAIL reset_d: got %b expected 0", d); end
    n_cmp++; if (d_stale !== 1'b0) begin n_fail++; $display("FAIL reset_d_stale: got %b expected 0", d_stale); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", mismatch_cnt); end
    n_cmp++; if (s_mismatch_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d expected 0", s_mismatch_cnt); end
  endtask

  task automatic test_step;
    reset_n = 1'b1; a = 1'b1; b = 1'b0; c = 1'b1;
    tick;
    n_cmp++; if (d !== 1'b1) begin n_fail++; $display("FAIL step1_d: got %b expected 1", d); end
    n_cmp++; if (d_stale !== 1'b0) begin n_fail++; $display("FAIL step1_d_stale: got %b expected 0", d_stale); end
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL step1_mismatch: got %b expected 1", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL step1_cnt: got %0d expected 1", mismatch_cnt); end
    tick;
    n_cmp++; if (d !== 1'b1) begin n_fail++; $display("FAIL step2_d: got %b expected 1", d); end
    n_cmp++; if (d_stale !== 1'b1) begin n_fail++; $display("FAIL step2_d_stale: got %b expected 1", d_stale); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL step2_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL step2_cnt: got %0d expected 1", mismatch_cnt); end
  endtask

  // c=0 forces all three data outputs low; a cnt_clr on that edge only clears the counter.
  task automatic test_c_zero;
    a = 1'b1; b = 1'b1; c = 1'b0; cnt_clr = 1'b1;
    tick;
    n_cmp++; if (d !== 1'b0) begin n_fail++; $display("FAIL czero_d: got %b expected 0", d); end
    n_cmp++; if (d_stale !== 1'b0) begin n_fail++; $display("FAIL czero_d_stale: got %b expected 0", d_stale); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL czero_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL czero_cnt: got %0d expected 0", mismatch_cnt); end
    // r_x now holds 1 (a|b=1), so c=1 with a=b=0 exposes the late OR term on the stale path.
    cnt_clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b1;
    tick;
    n_cmp++; if (d !== 1'b0) begin n_fail++; $display("FAIL hist_d: got %b expected 0", d); end
    n_cmp++; if (d_stale !== 1'b1) begin n_fail++; $display("FAIL hist_d_stale: got %b expected 1", d_stale); end
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL hist_mismatch: got %b expected 1", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL hist_cnt: got %0d expected 1", mismatch_cnt); end
  endtask

  task automatic test_sweep;
    logic prev_or;
    logic e_d;
    logic e_stale;
    logic e_mis;
    int   e_cnt;
    int   e_sat;
    reset_n = 1'b0; cnt_clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    tick;
    reset_n = 1'b1;
    prev_or = 1'b0; e_cnt = 0; e_sat = 0;
    for (int k = 0; k < 600; k++) begin
      a = 1'(k / 2);
      b = 1'(k / 10);
      c = 1'(k / 20);
      tick;
      e_d     = (a | b) & c;
      e_stale = prev_or & c;
      e_mis   = e_d ^ e_stale;
      if (e_mis) begin
        if (e_cnt < 65535) e_cnt++;
        if (e_sat < 3) e_sat++;
      end
      n_cmp++; if (d !== e_d) begin n_fail++; $display("FAIL sweep_d[%0d]: got %b expected %b", k, d, e_d); end
      n_cmp++; if (d_stale !== e_stale) begin n_fail++; $display("FAIL sweep_d_stale[%0d]: got %b expected %b", k, d_stale, e_stale); end
      n_cmp++; if (mismatch !== e_mis) begin n_fail++; $display("FAIL sweep_mismatch[%0d]: got %b expected %b", k, mismatch, e_mis); end
      n_cmp++; if (mismatch_cnt !== 16'(e_cnt)) begin n_fail++; $display("FAIL sweep_cnt[%0d]: got %0d expected %0d", k, mismatch_cnt, e_cnt); end
      n_cmp++; if (s_mismatch_cnt !== 2'(e_sat)) begin n_fail++; $display("FAIL sweep_sat_cnt[%0d]: got %0d expected %0d", k, s_mismatch_cnt, e_sat); end
      prev_or = a | b;
    end
  endtask

  // Alternating a with c=1 mismatches on every edge: the 2-bit counter stops at 3, the 16-bit one keeps counting.
  task automatic test_saturation;
    reset_n = 1'b0; cnt_clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b1;
    tick;
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      a = 1'(k);
      tick;
      n_cmp++; if (s_mismatch != 1'b1) begin n_fail++; $display("FAIL sat_mismatch[%0d]: got %b expected 1", k, s_mismatch); end
      n_cmp++; if (s_mismatch_cnt !== 2'((k > 3) ? 3 : k)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, s_mismatch_cnt, (k > 3) ? 3 : k); end
      n_cmp++; if (mismatch_cnt !== 16'(k)) begin n_fail++; $display("FAIL sat_wide_cnt[%0d]: got %0d expected %0d", k, mismatch_cnt, k); end
    end
  endtask

  // Entered with r_x=0 (last a was 0), so a=1,c=1 mismatches on the clearing edge.
  task automatic test_clear;
    a = 1'b1; b = 1'b0; c = 1'b1; cnt_clr = 1'b1;
    tick;
    n_cmp++; if (d !== 1'b1) begin n_fail++; $display("FAIL clr_d: got %b expected 1", d); end
    n_cmp++; if (d_stale !== 1'b0) begin n_fail++; $display("FAIL clr_d_stale: got %b expected 0", d_stale); end
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL clr_mismatch: got %b expected 1", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", mismatch_cnt); end
    n_cmp++; if (s_mismatch_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_sat_cnt: got %0d expected 0", s_mismatch_cnt); end
    cnt_clr = 1'b0;
    tick;
    n_cmp++; if (d_stale !== 1'b1) begin n_fail++; $display("FAIL clr_after_d_stale: got %b expected 1", d_stale); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL clr_after_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_after_cnt: got %0d expected 0", mismatch_cnt); end
  endtask

  // Reset wins over cnt_clr and data, and wipes r_x so the first edge after release mismatches again.
  task automatic test_mid_reset;
    a = 1'b1; b = 1'b0; c = 1'b1; cnt_clr = 1'b0;
    tick;
    reset_n = 1'b0; cnt_clr = 1'b1;
    tick;
    n_cmp++; if ({d, d_stale, mismatch} !== 3'b000) begin n_fail++; $display("FAIL midrst_outputs: got %b expected 000", {d, d_stale, mismatch}); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", mismatch_cnt); end
    reset_n = 1'b1; cnt_clr = 1'b0;
    tick;
    n_cmp++; if (d !== 1'b1) begin n_fail++; $display("FAIL post_rst_d: got %b expected 1", d); end
    n_cmp++; if (d_stale !== 1'b0) begin n_fail++; $display("FAIL post_rst_d_stale: got %b expected 0", d_stale); end
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL post_rst_mismatch: got %b expected 1", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL post_rst_cnt: got %0d expected 1", mismatch_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; cnt_clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    #2;
    test_reset;
    test_step;
    test_c_zero;
    test_sweep;
    test_saturation;
    test_clear;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
